// File: rtl/l1_cache_pkg.sv
// Shared types and geometry for the 2-way, 8-set L1 cache control slice.
package l1_cache_pkg;

    localparam int NUM_WAYS = 2;
    localparam int NUM_SETS = 8;

    typedef logic [$clog2(NUM_WAYS)-1:0] way_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    function automatic logic [NUM_WAYS-1:0] way_onehot(input way_t w);
        logic [NUM_WAYS-1:0] oh;
        oh    = '0;
        oh[w] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/l1_sat_counter.sv
// Saturating up-counter used for the optional L1 performance counters.
module l1_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/l1_cache_control.sv
// Control FSM for the 2-way L1 cache: hits, writeback and allocate sequencing.
// Optional performance counters are built when L1_PERF_CNT_EN is defined.
module l1_cache_control
    import l1_cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic                mem_resp,
    input  logic                hit0,
    input  logic                hit1,
    input  logic                dirty0,
    input  logic                dirty1,
    input  logic                lru,
    input  logic                pmem_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic                pmem_addr_sel,
    output logic                data_sel,
    output logic [NUM_WAYS-1:0] data_we,
    output logic [NUM_WAYS-1:0] tag_we,
    output logic [NUM_WAYS-1:0] valid_we,
    output logic [NUM_WAYS-1:0] dirty_we,
    output logic                dirty_in,
`ifdef L1_PERF_CNT_EN
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count,
    output logic [CNT_W-1:0]    wb_count,
`endif
    output logic                lru_we,
    output logic                lru_in
);

    state_t state;
    way_t   victim_q;

    logic req, hit, victim_dirty;
    way_t hit_way;

    assign req          = mem_read | mem_write;
    assign hit          = hit0 | hit1;
    // Both hits set cannot happen legally; way 0 wins.
    assign hit_way      = hit0 ? way_t'(0) : way_t'(1);
    assign victim_dirty = lru ? dirty1 : dirty0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            victim_q <= '0;
        end else begin
            case (state)
                IDLE: if (req && !hit) begin
                    victim_q <= way_t'(lru);
                    state    <= victim_dirty ? WRITEBACK : ALLOCATE;
                end
                WRITEBACK: if (pmem_resp) state <= ALLOCATE;
                ALLOCATE:  if (pmem_resp) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        data_sel      = 1'b0;
        data_we       = '0;
        tag_we        = '0;
        valid_we      = '0;
        dirty_we      = '0;
        dirty_in      = 1'b0;
        lru_we        = 1'b0;
        lru_in        = 1'b0;
        case (state)
            IDLE: if (req && hit) begin
                mem_resp = 1'b1;
                lru_we   = 1'b1;
                lru_in   = ~hit_way;
                // A simultaneous read and write is handled as a write.
                if (mem_write) begin
                    data_we  = way_onehot(hit_way);
                    dirty_we = way_onehot(hit_way);
                    dirty_in = 1'b1;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    data_we  = way_onehot(victim_q);
                    tag_we   = way_onehot(victim_q);
                    valid_we = way_onehot(victim_q);
                    dirty_we = way_onehot(victim_q);
                    data_sel = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef L1_PERF_CNT_EN
    logic hit_inc, miss_inc, wb_inc;

    assign hit_inc  = (state == IDLE) && mem_resp;
    assign miss_inc = (state == IDLE) && req && !hit;
    assign wb_inc   = (state == WRITEBACK) && pmem_resp;

    l1_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk(clk), .rst(rst), .inc(hit_inc), .clear(1'b0), .count(hit_count)
    );
    l1_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk(clk), .rst(rst), .inc(miss_inc), .clear(1'b0), .count(miss_count)
    );
    l1_sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
        .clk(clk), .rst(rst), .inc(wb_inc), .clear(1'b0), .count(wb_count)
    );
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_l1_cache_control.sv
// Directed bench for l1_cache_control; counter checks apply when L1_PERF_CNT_EN is defined.
module tb_l1_cache_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_read, mem_write, mem_resp;
    logic       hit0, hit1, dirty0, dirty1, lru, pmem_resp;
    logic       pmem_read, pmem_write, pmem_addr_sel, data_sel, dirty_in, lru_we, lru_in;
    logic [1:0] data_we, tag_we, valid_we, dirty_we;
`ifdef L1_PERF_CNT_EN
    logic [15:0] hit_count, miss_count, wb_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l1_cache_control #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1), .lru(lru),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .data_sel(data_sel),
        .data_we(data_we), .tag_we(tag_we), .valid_we(valid_we), .dirty_we(dirty_we),
        .dirty_in(dirty_in),
`ifdef L1_PERF_CNT_EN
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
`endif
        .lru_we(lru_we), .lru_in(lru_in)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        mem_read = 0; mem_write = 0; hit0 = 0; hit1 = 0;
        dirty0 = 0; dirty1 = 0; lru = 0; pmem_resp = 0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // {mem_resp, pmem_read, pmem_write, pmem_addr_sel}
    function automatic logic [3:0] strb();
        return {mem_resp, pmem_read, pmem_write, pmem_addr_sel};
    endfunction

    // {data_we, tag_we, valid_we, dirty_we, dirty_in, data_sel}
    function automatic logic [9:0] wes();
        return {data_we, tag_we, valid_we, dirty_we, dirty_in, data_sel};
    endfunction

    initial begin
        clr_in();
        nxt(); nxt();
        #1;
        chk("rst_strobes", strb(), 4'b0000);
        chk("rst_we", wes(), 10'b0);
`ifdef L1_PERF_CNT_EN
        chk("rst_cnt", {hit_count, miss_count}, 32'h0);
`endif
        nxt(); rst = 0;

        // read hit way1
        nxt(); mem_read = 1; hit1 = 1; #1;
        chk("t1_strobes", strb(), 4'b1000);
        chk("t1_lru", {lru_we, lru_in}, 2'b10);
        chk("t1_we", wes(), 10'b0);

        // write hit way0
        nxt(); clr_in(); mem_write = 1; hit0 = 1; #1;
        chk("t2_we", wes(), {2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0});
        chk("t2_lru_resp", {lru_we, lru_in, mem_resp}, 3'b111);

        // both hits on a write: way 0
        nxt(); hit1 = 1; #1;
        chk("both_hit", {data_we, lru_in, mem_resp}, 4'b0111);

        // read+write together behaves as write, hit way1
        nxt(); clr_in(); mem_read = 1; mem_write = 1; hit1 = 1; #1;
        chk("rd_wr", {data_we, dirty_we, dirty_in, lru_in, mem_resp}, 7'b1010101);

        // clean miss, victim way1; dirty0 set to show only the victim's dirty bit matters
        nxt(); clr_in(); mem_read = 1; lru = 1; dirty0 = 1; #1;
        chk("t3_idle_miss", strb(), 4'b0000);
        nxt(); #1;
        chk("t3_alloc", strb(), 4'b0100);
        for (int i = 0; i < 2; i++) begin
            nxt(); #1;
            chk("t3_alloc_hold", {strb(), wes()}, {4'b0100, 10'b0});
        end
        nxt(); pmem_resp = 1; #1;
        chk("t3_fill", wes(), {2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1});
        chk("t3_fill_noresp", strb(), 4'b0100);
        nxt(); pmem_resp = 0; hit1 = 1; #1;
        chk("t3_rehit", {strb(), lru_in}, 5'b10000);

        // dirty miss, victim way0
        nxt(); clr_in(); mem_read = 1; lru = 0; dirty0 = 1; #1;
        chk("t4_idle_miss", strb(), 4'b0000);
        nxt(); #1;
        chk("t4_wb", strb(), 4'b0011);
        nxt(); pmem_resp = 1; #1;
        chk("t4_wb_done", {strb(), wes()}, {4'b0011, 10'b0});
        nxt(); pmem_resp = 0; #1;
        chk("t4_alloc", strb(), 4'b0100);
        nxt(); pmem_resp = 1; #1;
        chk("t4_fill", wes(), {2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1});
`ifdef L1_PERF_CNT_EN
        chk("t4_wb_count", wb_count, 16'd1);
`endif
        nxt(); pmem_resp = 0; hit0 = 1; #1;
        chk("t4_rehit", strb(), 4'b1000);

        // dirty miss victim way1, then lru flips and the request drops
        nxt(); clr_in(); mem_write = 1; lru = 1; dirty1 = 1; #1;
        chk("t5_idle_miss", strb(), 4'b0000);
        nxt(); lru = 0; mem_write = 0; #1;
        chk("t5_wb", strb(), 4'b0011);
        nxt(); pmem_resp = 1; #1;
        chk("t5_wb_done", strb(), 4'b0011);
        nxt(); pmem_resp = 0; #1;
        chk("t5_alloc", strb(), 4'b0100);
        nxt(); pmem_resp = 1; #1;
        chk("t5_fill", {mem_resp, wes()}, {1'b0, 2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1});
        nxt(); pmem_resp = 0; #1;
        chk("t5_idle", {strb(), wes(), lru_we}, 15'b0);
`ifdef L1_PERF_CNT_EN
        chk("t5_hit_count", hit_count, 16'd6);
        chk("t5_miss_count", miss_count, 16'd3);
        chk("t5_wb_count", wb_count, 16'd2);
`endif

        // reset mid-allocate
        nxt(); mem_read = 1; lru = 0; #1;
        nxt(); #1;
        chk("t6_alloc", strb(), 4'b0100);
        #1 rst = 1;
        #1;
        chk("t6_rst_drop", strb(), 4'b0000);
`ifdef L1_PERF_CNT_EN
        chk("t6_cnt_clr", {hit_count, miss_count}, 32'h0);
        chk("t6_wb_clr", wb_count, 16'h0);
`endif
        nxt(); clr_in(); rst = 0;
        nxt(); mem_read = 1; hit0 = 1; #1;
        chk("t6_idle_hit", strb(), 4'b1000);
`ifdef L1_PERF_CNT_EN
        repeat (65540) nxt();
        #1;
        chk("t6_sat", hit_count, 16'hFFFF);
        nxt(); #1;
        chk("t6_sat_hold", hit_count, 16'hFFFF);
`endif

        nxt(); clr_in();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
